// File: rtl/effect_run_ctrl.sv
// effect_run_ctrl: launches one effect-core run per command, then streams the
// selected output frame out of the frame buffer through a 2-entry FIFO.
module effect_run_ctrl #(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 96,
    parameter int MAX_PIX = 8192
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_sel,
    input  logic [31:0]       cmd_width,
    input  logic [31:0]       cmd_height,
    output logic              core_start,
    input  logic              core_ready,
    input  logic              core_done,
    input  logic              core_idle,
    output logic [31:0]       core_width,
    output logic [31:0]       core_height,
    output logic [3:0]        buf_sel,
    output logic              buf_ce,
    output logic [ADDR_W-1:0] buf_addr,
    input  logic [DATA_W-1:0] buf_q,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_last,
    output logic              busy,
    output logic              err
);

    localparam int          NPIX_W    = $clog2(MAX_PIX + 1);
    localparam logic [63:0] MAX_PIX64 = 64'(MAX_PIX);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_WAIT_DONE = 3'd2;
    localparam logic [2:0] S_READ      = 3'd3;
    localparam logic [2:0] S_FLUSH     = 3'd4;

    logic [1:0]        rst_sync;
    logic              rst_n;
    logic [2:0]        state;
    logic [NPIX_W-1:0] npix;
    logic [NPIX_W-1:0] rd_addr;
    logic              inflight;
    logic              inflight_last;
    logic              head_valid;
    logic              head_last;
    logic              tail_valid;
    logic              tail_last;
    logic [DATA_W-1:0] tail_data;

    logic [63:0]       npix_calc;
    logic              cmd_legal;
    logic              cmd_fire;
    logic              pop;
    logic              push;
    logic              issue;
    logic              issue_last;
    logic [2:0]        occ;

    // Reset asserts immediately but releases only after two clean clock edges.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    always_comb begin
        npix_calc  = {32'd0, cmd_width} * {32'd0, cmd_height};
        cmd_legal  = (cmd_sel != 4'd0) && (cmd_sel <= 4'd9) &&
                     (npix_calc != 64'd0) && (npix_calc <= MAX_PIX64);
        cmd_ready  = rst_n && (state == S_IDLE) && core_idle;
        cmd_fire   = cmd_valid && cmd_ready;
        pop        = head_valid && pix_ready;
        push       = inflight;
        occ        = {2'b00, head_valid} + {2'b00, tail_valid} + {2'b00, inflight};
        // A slot freed by this cycle's pop can be reused at once, which is what
        // lets the stream sustain one pixel per cycle with only two entries.
        issue      = (state == S_READ) && (rd_addr < npix) &&
                     ((occ - {2'b00, pop}) < 3'd2);
        issue_last = (rd_addr == (npix - NPIX_W'(1)));
        buf_ce     = issue;
        buf_addr   = issue ? ADDR_W'(rd_addr) : '0;
        pix_valid  = head_valid;
        pix_last   = head_valid && head_last;
        busy       = (state != S_IDLE);
    end

    always_ff @(posedge ap_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            core_start  <= 1'b0;
            buf_sel     <= 4'd0;
            core_width  <= 32'd0;
            core_height <= 32'd0;
            npix        <= '0;
            rd_addr     <= '0;
            err         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_fire) begin
                        if (cmd_legal) begin
                            buf_sel     <= cmd_sel;
                            core_width  <= cmd_width;
                            core_height <= cmd_height;
                            npix        <= npix_calc[NPIX_W-1:0];
                            err         <= 1'b0;
                            core_start  <= 1'b1;
                            state       <= S_START;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    // A done arriving alongside ready means the core already finished.
                    if (core_ready) begin
                        core_start <= 1'b0;
                        rd_addr    <= '0;
                        state      <= core_done ? S_READ : S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (core_done) begin
                        rd_addr <= '0;
                        state   <= S_READ;
                    end
                end
                S_READ: begin
                    if (issue) begin
                        rd_addr <= rd_addr + NPIX_W'(1);
                        if (issue_last) begin
                            state <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (pop && head_last) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Head register drives pix_data directly; the tail only fills while the head stalls.
    always_ff @(posedge ap_clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            head_valid    <= 1'b0;
            head_last     <= 1'b0;
            tail_valid    <= 1'b0;
            tail_last     <= 1'b0;
            pix_data      <= '0;
            tail_data     <= '0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && issue_last;
            if (pop) begin
                if (tail_valid) begin
                    pix_data   <= tail_data;
                    head_last  <= tail_last;
                    tail_valid <= push;
                    if (push) begin
                        tail_data <= buf_q;
                        tail_last <= inflight_last;
                    end
                end else begin
                    head_valid <= push;
                    head_last  <= push && inflight_last;
                    if (push) begin
                        pix_data <= buf_q;
                    end
                end
            end else if (push) begin
                if (!head_valid) begin
                    head_valid <= 1'b1;
                    head_last  <= inflight_last;
                    pix_data   <= buf_q;
                end else begin
                    tail_valid <= 1'b1;
                    tail_last  <= inflight_last;
                    tail_data  <= buf_q;
                end
            end
        end
    end

endmodule
